// File: rtl/sevenseg_bcd_scan_pkg.sv
// Shared constants, FSM encoding and the digit-to-segment decoder for the
// seven-segment BCD display stage.
package sevenseg_bcd_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 16;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Largest value that fits in four decimal digits.
  localparam logic [BIN_W-1:0] MAX_DISPLAY = 16'd9999;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_e;

  // BCD digit to active-low segment pattern; non-decimal codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_bcd_scan_bin2bcd_seq.sv
// Sequential double-dabble converter: one load, 16 shift cycles, one latch
// cycle in which done is high and bcd holds the four result digits.
module bin2bcd_seq
  import sevenseg_bcd_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e                state_q, state_d;
  logic [BCD_W+BIN_W-1:0]     shift_q, shift_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(input logic [BCD_W+BIN_W-1:0] s);
    logic [BCD_W+BIN_W-1:0] t;
    t = s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (t[BIN_W+4*k +: 4] >= 4'd5) t[BIN_W+4*k +: 4] = t[BIN_W+4*k +: 4] + 4'd3;
    end
    return {t[BCD_W+BIN_W-2:0], 1'b0};
  endfunction

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every variable gets a hold default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d = {{BCD_W{1'b0}}, value};
          cnt_d   = '0;
          ovf_d   = (value > MAX_DISPLAY);
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        shift_d = dabble_step(shift_q);
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_LATCH);
  assign ovf  = ovf_q;
  assign bcd  = shift_q[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/sevenseg_bcd_scan.sv
// Display stage: buffers incoming values, converts them to BCD and scans the
// four digits onto a common-anode seven-segment display.
module sevenseg_bcd_scan
  import sevenseg_bcd_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  output logic             busy,
  output logic [3:0]       an,
  output logic             ca,
  output logic             cb,
  output logic             cc,
  output logic             cd,
  output logic             ce,
  output logic             cf,
  output logic             cg
);

  localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic             conv_busy, conv_done, conv_ovf, conv_load;
  logic [BCD_W-1:0] conv_bcd;
  logic [BIN_W-1:0] conv_value;

  logic             pending_q, pending_d;
  logic [BIN_W-1:0] pending_val_q, pending_val_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             disp_ovf_q, disp_ovf_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [NUM_DIGITS-1:0] lead_zero;

  // A fresh strobe wins over a buffered value when both are ready at once.
  assign conv_load  = !conv_busy && (value_valid || pending_q);
  assign conv_value = value_valid ? value : pending_val_q;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load),
    .value (conv_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .ovf   (conv_ovf),
    .bcd   (conv_bcd)
  );

  // All parent state, including the display digits and registered outputs.
  // NOTE: the display digits are a handful of flops, not a RAM, so they are
  // reset along with everything else and the panel starts at a known "0".
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= 1'b0;
      pending_val_q <= '0;
      disp_q        <= '0;
      disp_ovf_q    <= 1'b0;
      refresh_q     <= '0;
      idx_q         <= '0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
    end else begin
      pending_q     <= pending_d;
      pending_val_q <= pending_val_d;
      disp_q        <= disp_d;
      disp_ovf_q    <= disp_ovf_d;
      refresh_q     <= refresh_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  // Pending buffer, display latch and refresh scan next-state.
  always_comb begin
    pending_d     = pending_q;
    pending_val_d = pending_val_q;
    disp_d        = disp_q;
    disp_ovf_d    = disp_ovf_q;
    refresh_d     = refresh_q + CNT_W'(1);
    idx_d         = idx_q;

    if (conv_busy) begin
      if (value_valid) begin
        pending_d     = 1'b1;
        pending_val_d = value;
      end
    end else if (conv_load) begin
      pending_d = 1'b0;
    end

    if (conv_done) begin
      disp_d     = conv_bcd;
      disp_ovf_d = conv_ovf;
    end

    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Digit mux, leading-zero blanking and segment decode for the next output.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (disp_q[BCD_W-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
      lead_zero[k] = lead_zero[k+1] && (disp_q[4*k +: 4] == 4'd0);
    end

    an_d = ~(4'b0001 << idx_q);
    if (disp_ovf_q)                    seg_d = SEG_DASH;
    else if (BLANK_LZ && lead_zero[idx_q]) seg_d = SEG_BLANK;
    else                               seg_d = seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
  end

  assign busy = conv_busy;
  assign an   = an_q;
  assign {cg, cf, ce, cd, cc, cb, ca} = seg_q;

endmodule

// File: tb/tb_sevenseg_bcd_scan.sv
// Directed bench for sevenseg_bcd_scan: two instances (blanking on / off)
// share stimulus; expected segment patterns are written out by hand.
module tb_sevenseg_bcd_scan;

  // Hand-written active-low patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] P0  = 7'b1000000;
  localparam logic [6:0] P1  = 7'b1111001;
  localparam logic [6:0] P2  = 7'b0100100;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P4  = 7'b0011001;
  localparam logic [6:0] P5  = 7'b0010010;
  localparam logic [6:0] P7  = 7'b1111000;
  localparam logic [6:0] PBL = 7'b1111111;
  localparam logic [6:0] PDS = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;

  logic       busy0, busy1;
  logic [3:0] an0, an1;
  logic       ca0, cb0, cc0, cd0, ce0, cf0, cg0;
  logic       ca1, cb1, cc1, cd1, ce1, cf1, cg1;
  logic [6:0] seg0, seg1;

  int n_compared   = 0;
  int n_mismatched = 0;

  assign seg0 = {cg0, cf0, ce0, cd0, cc0, cb0, ca0};
  assign seg1 = {cg1, cf1, ce1, cd1, cc1, cb1, ca1};

  always #5 clk = ~clk;

  sevenseg_bcd_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy0), .an(an0),
    .ca(ca0), .cb(cb0), .cc(cc0), .cd(cd0), .ce(ce0), .cf(cf0), .cg(cg0)
  );

  sevenseg_bcd_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_all (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy1), .an(an1),
    .ca(ca1), .cb(cb1), .cc(cc1), .cd(cd1), .ce(ce1), .cf(cf1), .cg(cg1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle strobe; returns at the negedge of the cycle after the strobe.
  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  // Wait (bounded) until busy is low at a negedge; returns cycles waited.
  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy0 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    if (busy0) check({tag, " idle timeout"}, 32'(busy0), 32'd0);
  endtask

  // Sample 16 cycles; each sample must light exactly one digit in scan
  // order and show the expected pattern for it. exp = {d3,d2,d1,d0}.
  task automatic check_display(input string tag, input bit sel, input logic [27:0] exp);
    int         prev;
    int         idx;
    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic [3:0] seen;
    prev = -1;
    seen = '0;
    for (int s = 0; s < 16; s++) begin
      an_s  = sel ? an1 : an0;
      seg_s = sel ? seg1 : seg0;
      idx   = -1;
      for (int i = 0; i < 4; i++) if (an_s == ~(4'b0001 << i)) idx = i;
      check({tag, " an one-low"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        check($sformatf("%s seg digit%0d", tag, idx), 32'(seg_s), 32'(exp[idx*7 +: 7]));
        if (prev >= 0 && idx != prev) check({tag, " scan order"}, 32'(idx), 32'((prev + 1) % 4));
        prev = idx;
      end
      @(negedge clk);
    end
    check({tag, " all digits scanned"}, 32'(seen), 32'hF);
  endtask

  int waited;
  int busy_cycles;

  initial begin
    reset       = 1'b1;
    value       = '0;
    value_valid = 1'b0;

    // 1: reset held 10 cycles -> dark, idle; then digit 0 shows "0".
    repeat (10) @(negedge clk);
    check("reset an", 32'(an0), 32'hF);
    check("reset segs", 32'(seg0), 32'(PBL));
    check("reset busy", 32'(busy0), 32'd0);
    check("reset an noblank", 32'(an1), 32'hF);
    reset = 1'b0;
    @(negedge clk);
    check_display("after reset", 1'b0, {PBL, PBL, PBL, P0});
    check_display("after reset noblank", 1'b1, {P0, P0, P0, P0});

    // 2: 1234 -> busy exactly 17 cycles, then digits 4,3,2,1 right to left.
    strobe(16'd1234);
    busy_cycles = 0;
    while (busy0 && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("1234 busy cycles", 32'(busy_cycles), 32'd17);
    @(negedge clk);
    check_display("1234", 1'b0, {P1, P2, P3, P4});
    check_display("1234 noblank", 1'b1, {P1, P2, P3, P4});

    // 3: 7 -> blanked leading zeros vs "0007".
    strobe(16'd7);
    wait_idle("7", waited);
    @(negedge clk);
    check_display("7 blank", 1'b0, {PBL, PBL, PBL, P7});
    check_display("7 noblank", 1'b1, {P0, P0, P0, P7});

    // 4: boundary just above 9999 and the maximum -> all dashes.
    strobe(16'd10000);
    wait_idle("10000", waited);
    @(negedge clk);
    check_display("10000 dash", 1'b0, {PDS, PDS, PDS, PDS});
    strobe(16'd65535);
    wait_idle("65535", waited);
    @(negedge clk);
    check_display("65535 dash", 1'b0, {PDS, PDS, PDS, PDS});
    check_display("65535 dash noblank", 1'b1, {PDS, PDS, PDS, PDS});

    // 5: 21, then 34 and 55 while busy -> 21 shown, then 55; 34 dropped.
    strobe(16'd21);
    strobe(16'd34);
    strobe(16'd55);
    wait_idle("21", waited);
    @(negedge clk);
    check("pending restarts conversion", 32'(busy0), 32'd1);
    check_display("21", 1'b0, {PBL, PBL, P2, P1});
    wait_idle("55", waited);
    @(negedge clk);
    check_display("55", 1'b0, {PBL, PBL, P5, P5});
    busy_cycles = 0;
    repeat (25) begin
      if (busy0) busy_cycles++;
      @(negedge clk);
    end
    check("no third conversion", 32'(busy_cycles), 32'd0);

    // 6: reset mid-conversion of 89 -> idle at once, display back to "0".
    strobe(16'd89);
    repeat (5) @(negedge clk);
    check("89 converting", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset aborts busy", 32'(busy0), 32'd0);
    reset = 1'b0;
    busy_cycles = 0;
    repeat (30) begin
      if (busy0) busy_cycles++;
      @(negedge clk);
    end
    check("no busy after abort", 32'(busy_cycles), 32'd0);
    check_display("after abort", 1'b0, {PBL, PBL, PBL, P0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
